sdram_output_layer: RTL and testbench

Output-layer stage of the FPGA digit classifier, directly downstream of the hidden-layer SDRAM master. It consumes that stage's 200 signed 16-bit hidden-node sums from SDRAM and computes 10 output scores as dot products against output weights held in SDRAM. It then selects the winning digit (argmax), writes the digit back to SDRAM and presents it on a port. It is an Avalon-MM master on the same SDRAM slave port, started by the controller once the hidden stage reports done.

---
 rtl/sdram_output_layer.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_sdram_output_layer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_output_layer.sv
// Output layer of the digit classifier: 200 hidden sums x 10 output weights read from SDRAM, argmax digit written back.
// Optional HIDDEN_RELU_EN clamps negative hidden values to zero before the MAC.
module sdram_output_layer #(
  parameter int unsigned HID_BASE = 158000,
  parameter int unsigned N_HID    = 200,
  parameter int unsigned WGT_BASE = 160000,
  parameter int unsigned N_OUT    = 10,
  parameter int unsigned RES_ADDR = 162000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_sig,
  output logic        done_sig,
  output logic        read_n,
  output logic        write_n,
  output logic        chipselect,
  input  logic        waitrequest,
  output logic [31:0] address,
  output logic [1:0]  byteenable,
  input  logic        readdatavalid,
  input  logic [15:0] readdata,
  output logic [15:0] writedata,
  output logic [3:0]  digit,
  output logic [3:0]  s
);

  localparam int unsigned CW   = $clog2(N_HID + 1);
  localparam int unsigned OW   = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 16;
  localparam int unsigned PW   = 32;
  localparam int unsigned ACCW = 40;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_HID   = 3'd1;
  localparam logic [2:0] S_WAIT_HID = 3'd2;
  localparam logic [2:0] S_RD_WGT   = 3'd3;
  localparam logic [2:0] S_WAIT_WGT = 3'd4;
  localparam logic [2:0] S_NEXT_OUT = 3'd5;
  localparam logic [2:0] S_WRITE    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [CW-1:0] C_N_HID  = CW'(N_HID);
  localparam logic [CW-1:0] C_LAST_I = CW'(N_HID - 1);
  localparam logic [OW-1:0] C_LAST_O = OW'(N_OUT - 1);

  logic [2:0]             r_state,    w_state_n;
  logic [CW-1:0]          r_issue,    w_issue_n;
  logic [CW-1:0]          r_resp,     w_resp_n;
  logic [OW-1:0]          r_o,        w_o_n;
  logic [AW-1:0]          r_addr,     w_addr_n;
  logic [AW-1:0]          r_wbase,    w_wbase_n;
  logic                   r_read_n,   w_read_n_n;
  logic                   r_write_n,  w_write_n_n;
  logic [DW-1:0]          r_wdata,    w_wdata_n;
  logic                   r_done,     w_done_n;
  logic [OW-1:0]          r_digit,    w_digit_n;
  logic signed [ACCW-1:0] r_acc,      w_acc_n;
  logic signed [ACCW-1:0] r_best,     w_best_n;
  logic [OW-1:0]          r_best_idx, w_best_idx_n;
  logic signed [PW-1:0]   r_prod,     w_prod_n;
  logic                   r_prod_v,   w_prod_v_n;
  logic                   r_cs;
  logic [1:0]             r_be;

  logic                   w_accept;
  logic                   w_rsp_ok;
  logic                   w_hid_we;
  logic [CW-1:0]          w_hid_idx;
  logic signed [DW-1:0]   w_hid_raw;
  logic signed [DW-1:0]   w_hid_f;
  logic signed [DW-1:0]   w_rdata;
  logic signed [PW-1:0]   w_prod;
  logic                   w_take;
  logic [OW-1:0]          w_win_idx;

  logic signed [DW-1:0]   r_hid_buf [N_HID];

  assign w_accept  = !r_read_n && !waitrequest;
  // Responses beyond the expected count (stray or late) never advance the counter.
  assign w_rsp_ok  = readdatavalid && (r_resp < C_N_HID);
  assign w_hid_idx = (r_resp < C_N_HID) ? r_resp : '0;
  assign w_hid_raw = r_hid_buf[w_hid_idx];
  assign w_rdata   = $signed(readdata);

`ifdef HIDDEN_RELU_EN
  assign w_hid_f = w_hid_raw[DW-1] ? '0 : w_hid_raw;
`else
  assign w_hid_f = w_hid_raw;
`endif

  assign w_prod    = PW'(w_hid_f) * PW'(w_rdata);
  // Output 0 always seeds best; later outputs need a strict win so ties keep the lower index.
  assign w_take    = (r_o == '0) || (r_acc > r_best);
  assign w_win_idx = w_take ? r_o : r_best_idx;

  // Hidden-value buffer, filled in response order.
  always_ff @(posedge clk) begin
    if (w_hid_we) begin
      r_hid_buf[w_hid_idx] <= w_rdata;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    w_state_n    = r_state;
    w_issue_n    = r_issue;
    w_resp_n     = r_resp;
    w_o_n        = r_o;
    w_addr_n     = r_addr;
    w_wbase_n    = r_wbase;
    w_read_n_n   = r_read_n;
    w_write_n_n  = r_write_n;
    w_wdata_n    = r_wdata;
    w_done_n     = r_done;
    w_digit_n    = r_digit;
    w_acc_n      = r_acc;
    w_best_n     = r_best;
    w_best_idx_n = r_best_idx;
    w_prod_n     = r_prod;
    w_prod_v_n   = 1'b0;
    w_hid_we     = 1'b0;

    if (r_prod_v) begin
      w_acc_n = r_acc + ACCW'(r_prod);
    end

    case (r_state)
      S_IDLE: begin
        w_issue_n    = '0;
        w_resp_n     = '0;
        w_o_n        = '0;
        w_acc_n      = '0;
        w_best_n     = '0;
        w_best_idx_n = '0;
        w_wbase_n    = AW'(WGT_BASE);
        w_read_n_n   = 1'b1;
        w_write_n_n  = 1'b1;
        if (start_sig) begin
          w_state_n  = S_RD_HID;
          w_read_n_n = 1'b0;
          w_addr_n   = AW'(HID_BASE);
        end
      end

      S_RD_HID: begin
        if (w_rsp_ok) begin
          w_hid_we = 1'b1;
          w_resp_n = r_resp + CW'(1);
        end
        if (w_accept) begin
          if (r_issue == C_LAST_I) begin
            w_read_n_n = 1'b1;
            w_state_n  = S_WAIT_HID;
          end else begin
            w_issue_n = r_issue + CW'(1);
            w_addr_n  = r_addr + AW'(1);
          end
        end
      end

      S_WAIT_HID: begin
        if (w_rsp_ok) begin
          w_hid_we = 1'b1;
          w_resp_n = r_resp + CW'(1);
        end
        if (r_resp == C_N_HID) begin
          w_state_n  = S_RD_WGT;
          w_resp_n   = '0;
          w_issue_n  = '0;
          w_read_n_n = 1'b0;
          w_addr_n   = AW'(WGT_BASE);
          w_wbase_n  = AW'(WGT_BASE);
        end
      end

      S_RD_WGT: begin
        if (w_rsp_ok) begin
          w_prod_n   = w_prod;
          w_prod_v_n = 1'b1;
          w_resp_n   = r_resp + CW'(1);
        end
        if (w_accept) begin
          if (r_issue == C_LAST_I) begin
            w_read_n_n = 1'b1;
            w_state_n  = S_WAIT_WGT;
          end else begin
            w_issue_n = r_issue + CW'(1);
            w_addr_n  = r_addr + AW'(1);
          end
        end
      end

      S_WAIT_WGT: begin
        if (w_rsp_ok) begin
          w_prod_n   = w_prod;
          w_prod_v_n = 1'b1;
          w_resp_n   = r_resp + CW'(1);
        end
        // Leave only once the last product has been folded into the accumulator.
        if ((r_resp == C_N_HID) && !r_prod_v) begin
          w_state_n = S_NEXT_OUT;
        end
      end

      S_NEXT_OUT: begin
        if (w_take) begin
          w_best_n = r_acc;
        end
        w_best_idx_n = w_win_idx;
        w_acc_n      = '0;
        w_resp_n     = '0;
        w_issue_n    = '0;
        if (r_o != C_LAST_O) begin
          w_o_n      = r_o + OW'(1);
          w_wbase_n  = r_wbase + AW'(N_HID);
          w_addr_n   = r_wbase + AW'(N_HID);
          w_read_n_n = 1'b0;
          w_state_n  = S_RD_WGT;
        end else begin
          w_write_n_n = 1'b0;
          w_addr_n    = AW'(RES_ADDR);
          w_wdata_n   = {12'd0, w_win_idx};
          w_state_n   = S_WRITE;
        end
      end

      S_WRITE: begin
        if (!r_write_n && !waitrequest) begin
          w_write_n_n = 1'b1;
          w_digit_n   = r_best_idx;
          w_done_n    = 1'b1;
          w_state_n   = S_DONE;
        end
      end

      S_DONE: begin
        if (!start_sig) begin
          w_done_n  = 1'b0;
          w_state_n = S_IDLE;
        end
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_issue    <= '0;
      r_resp     <= '0;
      r_o        <= '0;
      r_addr     <= '0;
      r_wbase    <= AW'(WGT_BASE);
      r_read_n   <= 1'b1;
      r_write_n  <= 1'b1;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_digit    <= '0;
      r_acc      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_prod     <= '0;
      r_prod_v   <= 1'b0;
      r_cs       <= 1'b1;
      r_be       <= 2'b11;
    end else begin
      r_state    <= w_state_n;
      r_issue    <= w_issue_n;
      r_resp     <= w_resp_n;
      r_o        <= w_o_n;
      r_addr     <= w_addr_n;
      r_wbase    <= w_wbase_n;
      r_read_n   <= w_read_n_n;
      r_write_n  <= w_write_n_n;
      r_wdata    <= w_wdata_n;
      r_done     <= w_done_n;
      r_digit    <= w_digit_n;
      r_acc      <= w_acc_n;
      r_best     <= w_best_n;
      r_best_idx <= w_best_idx_n;
      r_prod     <= w_prod_n;
      r_prod_v   <= w_prod_v_n;
      r_cs       <= 1'b1;
      r_be       <= 2'b11;
    end
  end

  assign done_sig   = r_done;
  assign read_n     = r_read_n;
  assign write_n    = r_write_n;
  assign chipselect = r_cs;
  assign address    = r_addr;
  assign byteenable = r_be;
  assign writedata  = r_wdata;
  assign digit      = r_digit;
  assign s          = {1'b0, r_state};

endmodule

// File: tb/tb_sdram_output_layer.sv
// Directed bench for sdram_output_layer with a behavioural SDRAM slave (programmable stall and read latency).
module tb_sdram_output_layer;

  localparam int OFF = 158000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_sig = 1'b0;
  logic        done_sig;
  logic        read_n;
  logic        write_n;
  logic        chipselect;
  logic        waitrequest = 1'b0;
  logic [31:0] address;
  logic [1:0]  byteenable;
  logic        readdatavalid = 1'b0;
  logic [15:0] readdata = 16'h0000;
  logic [15:0] writedata;
  logic [3:0]  digit;
  logic [3:0]  s;

  int n_checks = 0;
  int n_err    = 0;

  logic signed [15:0] mem [0:4000];
  int          cyc = 0;
  bit          stall_en = 1'b0;
  int          lat = 1;
  bit          stray_en = 1'b0;
  int          n_reads = 0;
  int          n_writes = 0;
  logic [31:0] last_waddr = '0;
  logic [15:0] last_wdata = '0;
  int          rq_due [$];
  logic [15:0] rq_data [$];

  sdram_output_layer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_sig     (start_sig),
    .done_sig      (done_sig),
    .read_n        (read_n),
    .write_n       (write_n),
    .chipselect    (chipselect),
    .waitrequest   (waitrequest),
    .address       (address),
    .byteenable    (byteenable),
    .readdatavalid (readdatavalid),
    .readdata      (readdata),
    .writedata     (writedata),
    .digit         (digit),
    .s             (s)
  );

  always #5 clk = ~clk;

  // Slave model: drives for the coming posedge, records what that edge accepts.
  always @(negedge clk) begin
    int a;
    cyc = cyc + 1;
    waitrequest = stall_en ? ((cyc % 4) != 0) : 1'b0;
    if (stray_en) begin
      readdatavalid = 1'b1;
      readdata      = 16'h1234;
    end else if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      readdatavalid = 1'b1;
      readdata      = rq_data.pop_front();
      void'(rq_due.pop_front());
    end else begin
      readdatavalid = 1'b0;
      readdata      = 16'h0000;
    end
    if (!read_n && !waitrequest) begin
      a = int'(address) - OFF;
      n_reads = n_reads + 1;
      rq_data.push_back((a >= 0 && a <= 4000) ? mem[a] : 16'h0000);
      rq_due.push_back(cyc + lat);
    end
    if (!write_n && !waitrequest) begin
      n_writes   = n_writes + 1;
      last_waddr = address;
      last_wdata = writedata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Kinds: 0 ones/out7=2, 1 alt +-5 with out0,1=+1 out2=-1, 2 alt with out4=-1 on negatives,
  // 3 tie 3/9 at 1000, 4 near-full-scale (needs >32-bit acc), 5 all-negative scores.
  task automatic load(input int kind);
    for (int h = 0; h < 200; h++) begin
      logic signed [15:0] hv;
      case (kind)
        0:       hv = 16'sd1;
        1, 2:    hv = (h % 2 == 0) ? 16'sd5 : -16'sd5;
        3:       hv = 16'sd5;
        4:       hv = 16'sd32767;
        default: hv = 16'sd3;
      endcase
      mem[h] = hv;
      for (int o = 0; o < 10; o++) begin
        logic signed [15:0] wv;
        case (kind)
          0:       wv = (o == 7) ? 16'sd2 : 16'sd1;
          1:       wv = (o < 2) ? 16'sd1 : ((o == 2) ? -16'sd1 : 16'sd0);
          2:       wv = (o == 4 && h % 2 == 1) ? -16'sd1 : 16'sd0;
          3:       wv = (o == 3 || o == 9) ? 16'sd1 : ((o == 0) ? -16'sd1 : 16'sd0);
          4:       wv = (o == 8) ? 16'sd32767 : 16'sd32766;
          default: wv = -16'(10 - o);
        endcase
        mem[2000 + o * 200 + h] = wv;
      end
    end
  endtask

  task automatic run_img(input string tag, input logic [3:0] expd);
    int k;
    n_reads   = 0;
    n_writes  = 0;
    start_sig = 1'b1;
    k = 0;
    while (done_sig !== 1'b1 && k < 30000) begin
      tick();
      k++;
    end
    check({tag, ":done"},   64'(done_sig),   64'(1));
    check({tag, ":digit"},  64'(digit),      64'(expd));
    check({tag, ":state"},  64'(s),          64'(7));
    check({tag, ":writes"}, 64'(n_writes),   64'(1));
    check({tag, ":waddr"},  64'(last_waddr), 64'(162000));
    check({tag, ":wdata"},  64'(last_wdata), 64'(expd));
    check({tag, ":reads"},  64'(n_reads),    64'(2200));
  endtask

  task automatic drop(input string tag, input logic [3:0] expd);
    start_sig = 1'b0;
    tick();
    check({tag, ":idle"},     64'(s),        64'(0));
    check({tag, ":done_lo"},  64'(done_sig), 64'(0));
    check({tag, ":digit_hold"}, 64'(digit),  64'(expd));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":s"},       64'(s),          64'(0));
    check({tag, ":read_n"},  64'(read_n),     64'(1));
    check({tag, ":write_n"}, 64'(write_n),    64'(1));
    check({tag, ":cs"},      64'(chipselect), 64'(1));
    check({tag, ":be"},      64'(byteenable), 64'(3));
    check({tag, ":addr"},    64'(address),    64'(0));
    check({tag, ":wdata"},   64'(writedata),  64'(0));
    check({tag, ":done"},    64'(done_sig),   64'(0));
    check({tag, ":digit"},   64'(digit),      64'(0));
  endtask

  initial begin
    int k;
    logic [3:0] relu_digit;
    for (int i = 0; i <= 4000; i++) mem[i] = 16'sd0;

    reset_n   = 1'b0;
    start_sig = 1'b0;
    repeat (3) tick();
    check_reset("rst");
    reset_n = 1'b1;
    tick();

    load(0);
    run_img("basic", 4'd7);
    drop("basic", 4'd7);

    stall_en = 1'b1;
    lat      = 5;
    run_img("stall", 4'd7);
    drop("stall", 4'd7);
    stall_en = 1'b0;
    lat      = 1;

    load(1);
    run_img("alt_tie", 4'd0);
    drop("alt_tie", 4'd0);

`ifdef HIDDEN_RELU_EN
    relu_digit = 4'd0;
`else
    relu_digit = 4'd4;
`endif
    load(2);
    run_img("relu_sel", relu_digit);
    drop("relu_sel", relu_digit);

    load(3);
    run_img("tie39", 4'd3);
    drop("tie39", 4'd3);

    load(4);
    run_img("wide_acc", 4'd8);
    drop("wide_acc", 4'd8);

    load(5);
    run_img("neg", 4'd9);
    repeat (20) tick();
    check("hold:state",  64'(s),        64'(7));
    check("hold:done",   64'(done_sig), 64'(1));
    check("hold:writes", 64'(n_writes), 64'(1));
    check("hold:reads",  64'(n_reads),  64'(2200));
    drop("hold", 4'd9);

    load(3);
    run_img("second", 4'd3);
    drop("second", 4'd3);

    // Abort during output 4's weight reads.
    load(0);
    start_sig = 1'b1;
    k = 0;
    while (!(read_n == 1'b0 && address >= 32'd160800 && address < 32'd161000) && k < 5000) begin
      tick();
      k++;
    end
    check("abort:reached_o4", 64'(k < 5000), 64'(1));
    reset_n   = 1'b0;
    start_sig = 1'b0;
    tick();
    check_reset("abort");
    reset_n = 1'b1;
    tick();
    rq_due.delete();
    rq_data.delete();
    stray_en = 1'b1;
    repeat (4) tick();
    stray_en = 1'b0;
    tick();
    check("abort:idle_after_stray", 64'(s), 64'(0));
    run_img("restart", 4'd7);
    drop("restart", 4'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
